// File: rtl/cut_scan_gen2.sv
// Parametrised circuit-under-test for per-scan BIST: sequence controller, down-counter,
// toggle clock and test-pattern register, with every flop stitched into NCHAINS scan chains.

module cut_scan_gen2_chain #(
    parameter int CL = 7
) (
    input  logic [CL-1:0] q,
    input  logic          si,
    output logic [CL-1:0] d,
    output logic          so
);
    // Serial entry at the chain MSB, exit at the chain LSB.
    if (CL > 1) begin : g_multi
        assign d = {si, q[CL-1:1]};
    end else begin : g_single
        assign d = si;
    end
    assign so = q[0];
endmodule

module cut_scan_gen2 #(
    parameter int CNT_W      = 5,
    parameter int LOAD_VAL   = 24,
    parameter int WRAP_VAL   = 25,
    parameter int TEST_W     = 2,
    parameter int HIST_DEPTH = 2,
    parameter int NCHAINS    = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               s,
    input  logic               dv,
    input  logic               l_in,
    input  logic [TEST_W-1:0]  test_in,
    input  logic               scan_en,
    input  logic [NCHAINS-1:0] scan_in,
    output logic [NCHAINS-1:0] scan_out,
    output logic               fz_L,
    output logic               lclk,
    output logic [CNT_W-1:0]   read_a,
    output logic [TEST_W-1:0]  test_out
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, LZ = 3'd1, WR = 3'd2, SS = 3'd3,
        SD   = 3'd4, STZ = 3'd5, WE = 3'd6, ILL = 3'd7
    } state_t;

    // Functional flops; the chain length is sized with one spare bit so the top of
    // the vector always carries at least one pad flop.
    localparam int FL      = 4 + CNT_W + TEST_W + HIST_DEPTH;
    localparam int L       = 5 + CNT_W + TEST_W + HIST_DEPTH;
    localparam int CL      = (L + NCHAINS - 1) / NCHAINS;
    localparam int TOT     = NCHAINS * CL;
    localparam int PAD_W   = TOT - FL;
    localparam int TO_LO   = HIST_DEPTH;
    localparam int LCLK_B  = HIST_DEPTH + TEST_W;
    localparam int CNT_LO  = LCLK_B + 1;
    localparam int ST_LO   = CNT_LO + CNT_W;
    localparam int PAD_LO  = ST_LO + 3;

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(LOAD_VAL);
    localparam logic [CNT_W-1:0] WRAP = CNT_W'(WRAP_VAL);

    logic [TOT-1:0]        f;
    logic [TOT-1:0]        f_func;
    logic [TOT-1:0]        f_scan;
    logic [PAD_W-1:0]      pad;
    state_t                state;
    state_t                nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic                  lclk_nxt;
    logic [TEST_W-1:0]     to_nxt;
    logic [HIST_DEPTH-1:0] hist;
    logic [HIST_DEPTH-1:0] hist_nxt;
    logic                  clear;
    logic                  load;
    logic                  comp;
    logic                  conflict;

    assign pad      = f[PAD_LO +: PAD_W];
    assign state    = state_t'(f[ST_LO +: 3]);
    assign cnt      = f[CNT_LO +: CNT_W];
    assign lclk     = f[LCLK_B];
    assign test_out = f[TO_LO +: TEST_W];
    assign hist     = f[0 +: HIST_DEPTH];
    assign read_a   = cnt;

    assign comp     = (test_out == test_in);
    assign conflict = &hist;

    // Next-state and control decode.
    always_comb begin
        nxt   = IDLE;
        clear = 1'b0;
        load  = 1'b0;
        fz_L  = 1'b0;
        case (state)
            IDLE: begin
                clear = 1'b1;
                nxt   = (s && !dv) ? WE : IDLE;
            end
            WE: begin
                clear = 1'b1;
                if (!s)      nxt = IDLE;
                else if (dv) nxt = LZ;
                else         nxt = WE;
            end
            LZ, WR: begin
                clear = 1'b1;
                load  = 1'b1;
                if (!s)        nxt = IDLE;
                else if (l_in) nxt = WR;
                else           nxt = SS;
            end
            SS: begin
                nxt = (!s || conflict) ? IDLE : SD;
            end
            SD: begin
                fz_L = 1'b1;
                if (!s || conflict)  nxt = IDLE;
                else if (cnt == '0)  nxt = STZ;
                else                 nxt = SD;
            end
            STZ: begin
                if (!s || conflict)  nxt = IDLE;
                else if (cnt == WRAP) nxt = SS;
                else                 nxt = STZ;
            end
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt  = cnt - CNT_W'(1);
        lclk_nxt = lclk ^ (cnt == WRAP);
        if (clear) begin
            cnt_nxt  = LOAD;
            lclk_nxt = 1'b0;
        end
        to_nxt = load ? test_in + TEST_W'(2) : test_out + TEST_W'(1);
    end

    if (HIST_DEPTH > 1) begin : g_hist
        assign hist_nxt = {hist[HIST_DEPTH-2:0], comp};
    end else begin : g_hist1
        assign hist_nxt = comp;
    end

    assign f_func = {pad, nxt, cnt_nxt, lclk_nxt, to_nxt, hist_nxt};

    for (genvar k = 0; k < NCHAINS; k++) begin : g_chain
        cut_scan_gen2_chain #(.CL(CL)) u_chain (
            .q  (f[k*CL +: CL]),
            .si (scan_in[k]),
            .d  (f_scan[k*CL +: CL]),
            .so (scan_out[k])
        );
    end

    // Leaving scan needs no capture cycle: the first functional edge consumes the loaded vector.
    always_ff @(posedge clock) begin
        if (reset)        f <= '0;
        else if (scan_en) f <= f_scan;
        else              f <= f_func;
    end
endmodule

// File: tb/tb_cut_scan_gen2.sv
// Directed bench for cut_scan_gen2: reset, entry path, count loop, conflict, scan and illegal state.

module tb_cut_scan_gen2;
    logic       clock = 1'b0;
    logic       reset, s, dv, l_in, scan_en;
    logic [1:0] test_in, scan_in;
    logic [1:0] scan_out;
    logic       fz_L, lclk;
    logic [4:0] read_a;
    logic [1:0] test_out;

    int vec  = 0;
    int miss = 0;
    logic [1:0]  m_to;
    logic [13:0] exp_f, pat, qv;

    cut_scan_gen2 dut (
        .clock(clock), .reset(reset), .s(s), .dv(dv), .l_in(l_in), .test_in(test_in),
        .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out), .fz_L(fz_L),
        .lclk(lclk), .read_a(read_a), .test_out(test_out)
    );

    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic adv_ti(input logic s_, input logic dv_, input logic l_, input logic ld, input logic [1:0] ti);
        s = s_; dv = dv_; l_in = l_; test_in = ti;
        step();
        m_to = ld ? ti + 2'd2 : m_to + 2'd1;
    endtask

    // Drive a test_in that never matches the current pattern register.
    task automatic adv(input logic s_, input logic dv_, input logic l_, input logic ld);
        adv_ti(s_, dv_, l_, ld, m_to + 2'd1);
    endtask

    task automatic test_reset;
        reset = 1'b1; scan_en = 1'b1; scan_in = 2'b11; s = 1'b1; dv = 1'b0; l_in = 1'b0; test_in = 2'd0;
        step();
        vec++; if ({read_a, lclk, test_out, fz_L, scan_out, 3'(dut.state)} !== 14'd0) begin
            miss++; $display("FAIL reset_over_scan: got %h want 0", {read_a, lclk, test_out, fz_L, scan_out, 3'(dut.state)}); end
        scan_en = 1'b0;
        step();
        vec++; if ({read_a, lclk, test_out, fz_L, scan_out, 3'(dut.state)} !== 14'd0) begin
            miss++; $display("FAIL reset_func: got %h want 0", {read_a, lclk, test_out, fz_L, scan_out, 3'(dut.state)}); end
        reset = 1'b0; m_to = 2'd0;
        vec++; if (read_a !== 5'd0) begin miss++; $display("FAIL release_cnt: got %0d want 0", read_a); end
        adv(1'b0, 1'b0, 1'b0, 1'b0);
        vec++; if (read_a !== 5'd24) begin miss++; $display("FAIL load_val: got %0d want 24", read_a); end
        vec++; if (test_out !== 2'd1) begin miss++; $display("FAIL idle_inc: got %0d want 1", test_out); end
    endtask

    task automatic test_entry;
        adv(1'b1, 1'b0, 1'b0, 1'b0);
        vec++; if (dut.state !== 3'd6 || test_out !== 2'd2) begin
            miss++; $display("FAIL entry_we: got st=%0d to=%0d want st=6 to=2", dut.state, test_out); end
        adv(1'b1, 1'b1, 1'b1, 1'b0);
        vec++; if (dut.state !== 3'd1 || test_out !== 2'd3) begin
            miss++; $display("FAIL entry_lz: got st=%0d to=%0d want st=1 to=3", dut.state, test_out); end
        adv(1'b1, 1'b1, 1'b1, 1'b1);
        vec++; if (dut.state !== 3'd2 || test_out !== 2'd2) begin
            miss++; $display("FAIL entry_wr1: got st=%0d to=%0d want st=2 to=2", dut.state, test_out); end
        adv(1'b1, 1'b1, 1'b1, 1'b1);
        vec++; if (dut.state !== 3'd2 || test_out !== 2'd1) begin
            miss++; $display("FAIL entry_wr2: got st=%0d to=%0d want st=2 to=1", dut.state, test_out); end
        adv(1'b1, 1'b0, 1'b0, 1'b1);
        vec++; if (dut.state !== 3'd3 || test_out !== 2'd0 || read_a !== 5'd24 || fz_L !== 1'b0) begin
            miss++; $display("FAIL entry_ss: got st=%0d to=%0d cnt=%0d fz=%b want st=3 to=0 cnt=24 fz=0",
                             dut.state, test_out, read_a, fz_L); end
    endtask

    task automatic test_count;
        for (int p = 0; p < 2; p++) begin
            adv(1'b1, 1'b0, 1'b0, 1'b0);
            vec++; if (dut.state !== 3'd4 || read_a !== 5'd23 || fz_L !== 1'b1) begin
                miss++; $display("FAIL count_sd_entry: got st=%0d cnt=%0d fz=%b want st=4 cnt=23 fz=1", dut.state, read_a, fz_L); end
            for (int i = 22; i >= 0; i--) begin
                adv(1'b1, 1'b0, 1'b0, 1'b0);
                vec++; if (read_a !== 5'(i) || fz_L !== 1'b1 || lclk !== 1'(p)) begin
                    miss++; $display("FAIL count_sd: got cnt=%0d fz=%b lclk=%b want cnt=%0d fz=1 lclk=%0d", read_a, fz_L, lclk, i, p); end
            end
            adv(1'b1, 1'b0, 1'b0, 1'b0);
            vec++; if (dut.state !== 3'd5 || read_a !== 5'd31 || fz_L !== 1'b0) begin
                miss++; $display("FAIL count_stz_entry: got st=%0d cnt=%0d fz=%b want st=5 cnt=31 fz=0", dut.state, read_a, fz_L); end
            for (int i = 30; i >= 25; i--) begin
                adv(1'b1, 1'b0, 1'b0, 1'b0);
                vec++; if (dut.state !== 3'd5 || read_a !== 5'(i)) begin
                    miss++; $display("FAIL count_stz: got st=%0d cnt=%0d want st=5 cnt=%0d", dut.state, read_a, i); end
            end
            adv(1'b1, 1'b0, 1'b0, 1'b0);
            vec++; if (dut.state !== 3'd3 || read_a !== 5'd24 || lclk !== 1'(1 - p)) begin
                miss++; $display("FAIL count_wrap: got st=%0d cnt=%0d lclk=%b want st=3 cnt=24 lclk=%0d", dut.state, read_a, lclk, 1 - p); end
        end
    endtask

    task automatic test_conflict;
        adv(1'b1, 1'b0, 1'b0, 1'b0);
        adv_ti(1'b1, 1'b0, 1'b0, 1'b0, m_to);
        vec++; if (dut.state !== 3'd4) begin miss++; $display("FAIL conflict_single_a: got st=%0d want 4", dut.state); end
        adv(1'b1, 1'b0, 1'b0, 1'b0);
        vec++; if (dut.state !== 3'd4 || fz_L !== 1'b1) begin
            miss++; $display("FAIL conflict_single_b: got st=%0d fz=%b want st=4 fz=1", dut.state, fz_L); end
        adv_ti(1'b1, 1'b0, 1'b0, 1'b0, m_to);
        adv_ti(1'b1, 1'b0, 1'b0, 1'b0, m_to);
        vec++; if (dut.state !== 3'd4 || read_a !== 5'd19) begin
            miss++; $display("FAIL conflict_latency: got st=%0d cnt=%0d want st=4 cnt=19", dut.state, read_a); end
        adv(1'b1, 1'b0, 1'b0, 1'b0);
        vec++; if (dut.state !== 3'd0 || fz_L !== 1'b0 || read_a !== 5'd18) begin
            miss++; $display("FAIL conflict_idle: got st=%0d fz=%b cnt=%0d want st=0 fz=0 cnt=18", dut.state, fz_L, read_a); end
    endtask

    task automatic test_scan;
        adv(1'b1, 1'b0, 1'b0, 1'b0);
        adv(1'b1, 1'b1, 1'b0, 1'b0);
        adv(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) adv(1'b1, 1'b0, 1'b0, 1'b0);
        vec++; if (dut.state !== 3'd4 || read_a !== 5'd20) begin
            miss++; $display("FAIL scan_pre: got st=%0d cnt=%0d want st=4 cnt=20", dut.state, read_a); end
        exp_f = {1'b0, 3'd4, 5'd20, 1'b0, m_to, 2'b00};
        pat   = {1'b1, 3'b011, 5'b10011, 1'b1, 2'b01, 2'b10};
        scan_en = 1'b1;
        for (int j = 0; j < 7; j++) begin
            vec++; if (scan_out !== {exp_f[7+j], exp_f[j]}) begin
                miss++; $display("FAIL scan_unload bit %0d: got %b want %b", j, scan_out, {exp_f[7+j], exp_f[j]}); end
            scan_in = {pat[7+j], pat[j]};
            step();
        end
        vec++; if (read_a !== 5'd19 || lclk !== 1'b1 || test_out !== 2'd1 || dut.state !== 3'd3 || fz_L !== 1'b0) begin
            miss++; $display("FAIL scan_loaded: got cnt=%0d lclk=%b to=%0d st=%0d fz=%b want 19 1 1 3 0",
                             read_a, lclk, test_out, dut.state, fz_L); end
        for (int j = 0; j < 7; j++) begin
            vec++; if (scan_out !== {pat[7+j], pat[j]}) begin
                miss++; $display("FAIL scan_reappear bit %0d: got %b want %b", j, scan_out, {pat[7+j], pat[j]}); end
            scan_in = {exp_f[7+j], exp_f[j]};
            step();
        end
        scan_en = 1'b0;
        vec++; if (read_a !== 5'd20 || dut.state !== 3'd4 || test_out !== m_to || fz_L !== 1'b1 || lclk !== 1'b0) begin
            miss++; $display("FAIL scan_frozen: got cnt=%0d st=%0d to=%0d fz=%b want cnt=20 st=4 to=%0d fz=1",
                             read_a, dut.state, test_out, fz_L, m_to); end
        adv(1'b1, 1'b0, 1'b0, 1'b0);
        vec++; if (read_a !== 5'd19 || dut.state !== 3'd4) begin
            miss++; $display("FAIL scan_resume: got cnt=%0d st=%0d want cnt=19 st=4", read_a, dut.state); end
    endtask

    task automatic test_illegal;
        qv = {1'b0, 3'b111, 5'd10, 1'b0, 2'b00, 2'b00};
        scan_en = 1'b1;
        for (int j = 0; j < 7; j++) begin
            scan_in = {qv[7+j], qv[j]};
            step();
        end
        scan_en = 1'b0;
        vec++; if (dut.state !== 3'd7 || fz_L !== 1'b0 || read_a !== 5'd10) begin
            miss++; $display("FAIL illegal_loaded: got st=%0d fz=%b cnt=%0d want st=7 fz=0 cnt=10", dut.state, fz_L, read_a); end
        m_to = 2'd0;
        adv(1'b1, 1'b0, 1'b0, 1'b0);
        vec++; if (dut.state !== 3'd0 || read_a !== 5'd9 || test_out !== 2'd1 || fz_L !== 1'b0) begin
            miss++; $display("FAIL illegal_exit: got st=%0d cnt=%0d to=%0d fz=%b want st=0 cnt=9 to=1 fz=0",
                             dut.state, read_a, test_out, fz_L); end
    endtask

    initial begin
        reset = 1'b1; s = 1'b0; dv = 1'b0; l_in = 1'b0; test_in = 2'd0; scan_en = 1'b0; scan_in = 2'b00;
        m_to = 2'd0;
        test_reset();
        test_entry();
        test_count();
        test_conflict();
        test_scan();
        test_illegal();
        test_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
